axi_err_slave: RTL and testbench

//  Full AXI4 terminating slave for unmapped address space: accepts any read or

---
 rtl/axi_err_slave_if.sv | 43 ++++
 rtl/axi_err_slave.sv | 173 +++++++++++++++++
 tb/tb_axi_err_slave.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_err_slave_if.sv
//------------------------------------------------------------------------------
// axi_err_slave_if: AXI4 signals seen by an error-terminating slave (no WDATA).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface axi_err_slave_if #(
  parameter int unsigned IDW = 2,
  parameter int unsigned DW  = 32
);
  logic           AWVALID;
  logic           AWREADY;
  logic [IDW-1:0] AWID;
  logic           WVALID;
  logic           WREADY;
  logic           WLAST;
  logic           BVALID;
  logic           BREADY;
  logic [IDW-1:0] BID;
  logic [1:0]     BRESP;
  logic           ARVALID;
  logic           ARREADY;
  logic [IDW-1:0] ARID;
  logic [7:0]     ARLEN;
  logic           RVALID;
  logic           RREADY;
  logic [IDW-1:0] RID;
  logic [DW-1:0]  RDATA;
  logic           RLAST;
  logic [1:0]     RRESP;

  modport slave (
    input  AWVALID, AWID, WVALID, WLAST, BREADY, ARVALID, ARID, ARLEN, RREADY,
    output AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RLAST, RRESP
  );

  modport master (
    output AWVALID, AWID, WVALID, WLAST, BREADY, ARVALID, ARID, ARLEN, RREADY,
    input  AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RLAST, RRESP
  );
endinterface

`default_nettype wire

// File: rtl/axi_err_slave.sv
//------------------------------------------------------------------------------
// axi_err_slave: AXI4 slave answering every burst with ERR_RESP; counts bursts.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi_err_slave #(
  parameter int unsigned C_AXI_ID_WIDTH   = 2,
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter logic [1:0]  ERR_RESP         = 2'b11,
  parameter int unsigned LGCOUNT          = 16,
  parameter bit          OPT_LOWPOWER     = 1'b0
) (
  input  wire logic               S_AXI_ACLK,
  input  wire logic               S_AXI_ARESET,
  axi_err_slave_if.slave          S_AXI,
  output logic [LGCOUNT-1:0]      o_wr_errors,
  output logic [LGCOUNT-1:0]      o_rd_errors
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

  wstate_e                   w_state_q, w_state_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [C_AXI_ID_WIDTH-1:0] bid_q, bid_d;
  logic [LGCOUNT-1:0]        wr_cnt_q, wr_cnt_d;

  rstate_e                   r_state_q, r_state_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic                      rlast_q, rlast_d;
  logic [C_AXI_ID_WIDTH-1:0] rid_q, rid_d;
  logic [7:0]                beats_q, beats_d;
  logic [LGCOUNT-1:0]        rd_cnt_q, rd_cnt_d;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      wr_cnt_q  <= '0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      beats_q   <= '0;
      rd_cnt_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      wr_cnt_q  <= wr_cnt_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      beats_q   <= beats_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Write path: AWLEN is never inspected, WLAST alone ends the data phase.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    wr_cnt_d  = wr_cnt_q;
    case (w_state_q)
      W_IDLE: begin
        if (S_AXI.AWVALID) begin
          bid_d     = S_AXI.AWID;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI.WVALID && S_AXI.WLAST) begin
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI.BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
          if (wr_cnt_q != {LGCOUNT{1'b1}})
            wr_cnt_d = wr_cnt_q + LGCOUNT'(1);
        end
      end
      default: begin
        w_state_d = W_IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Read path: beats_q counts remaining beats after the one on the bus.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    beats_d   = beats_q;
    rd_cnt_d  = rd_cnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (S_AXI.ARVALID) begin
          rid_d     = S_AXI.ARID;
          beats_d   = S_AXI.ARLEN;
          rlast_d   = (S_AXI.ARLEN == 8'd0);
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI.RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
            if (rd_cnt_q != {LGCOUNT{1'b1}})
              rd_cnt_d = rd_cnt_q + LGCOUNT'(1);
          end else begin
            beats_d = beats_q - 8'd1;
            rlast_d = (beats_q == 8'd1);
          end
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
  end

  assign S_AXI.AWREADY = awready_q;
  assign S_AXI.WREADY  = wready_q;
  assign S_AXI.BVALID  = bvalid_q;
  assign S_AXI.BID     = (OPT_LOWPOWER && !bvalid_q) ? '0 : bid_q;
  assign S_AXI.BRESP   = ERR_RESP;
  assign S_AXI.ARREADY = arready_q;
  assign S_AXI.RVALID  = rvalid_q;
  assign S_AXI.RID     = (OPT_LOWPOWER && !rvalid_q) ? '0 : rid_q;
  assign S_AXI.RDATA   = {C_AXI_DATA_WIDTH{1'b0}};
  assign S_AXI.RLAST   = rlast_q;
  assign S_AXI.RRESP   = ERR_RESP;
  assign o_wr_errors   = wr_cnt_q;
  assign o_rd_errors   = rd_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_err_slave.sv
//------------------------------------------------------------------------------
// tb_axi_err_slave: directed self-checking bench for axi_err_slave.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_err_slave;

  logic        clk;
  logic        rst;
  logic [15:0] wr_errors;
  logic [15:0] rd_errors;
  logic [1:0]  wr_errors2;
  logic [1:0]  rd_errors2;

  int n_total = 0;
  int n_bad   = 0;
  int exp_rd  = 0;
  int exp_wr  = 0;

  axi_err_slave_if #(.IDW(2), .DW(32)) s_axi ();
  axi_err_slave_if #(.IDW(2), .DW(32)) s2 ();

  axi_err_slave #(
    .C_AXI_ID_WIDTH(2), .C_AXI_DATA_WIDTH(32), .ERR_RESP(2'b11),
    .LGCOUNT(16), .OPT_LOWPOWER(1'b0)
  ) u_dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .S_AXI(s_axi),
    .o_wr_errors(wr_errors), .o_rd_errors(rd_errors)
  );

  // Small counters, low-power ID gating and SLVERR on a second instance.
  axi_err_slave #(
    .C_AXI_ID_WIDTH(2), .C_AXI_DATA_WIDTH(32), .ERR_RESP(2'b10),
    .LGCOUNT(2), .OPT_LOWPOWER(1'b1)
  ) u_dut2 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .S_AXI(s2),
    .o_wr_errors(wr_errors2), .o_rd_errors(rd_errors2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_read(input logic [1:0] id, input logic [7:0] len, input bit stall);
    int  beats;
    int  cyc;
    bit  hs;
    beats = 0;
    cyc   = 0;
    check("rd_arready", 32'(s_axi.ARREADY), 32'd1);
    s_axi.ARVALID = 1'b1;
    s_axi.ARID    = id;
    s_axi.ARLEN   = len;
    tick();
    s_axi.ARVALID = 1'b0;
    s_axi.ARID    = '0;
    s_axi.ARLEN   = '0;
    check("rd_arready_busy", 32'(s_axi.ARREADY), 32'd0);
    while (beats <= int'(len) && cyc < 1200) begin
      s_axi.RREADY = stall ? cyc[0] : 1'b1;
      check("rd_rvalid", 32'(s_axi.RVALID), 32'd1);
      check("rd_rid", 32'(s_axi.RID), 32'(id));
      check("rd_rlast", 32'(s_axi.RLAST), 32'(beats == int'(len)));
      check("rd_rresp", 32'(s_axi.RRESP), 32'd3);
      check("rd_rdata", s_axi.RDATA, 32'd0);
      hs = s_axi.RVALID && s_axi.RREADY;
      tick();
      cyc++;
      if (hs) beats++;
    end
    s_axi.RREADY = 1'b0;
    exp_rd++;
    check("rd_beats", 32'(beats), 32'(int'(len) + 1));
    check("rd_rvalid_end", 32'(s_axi.RVALID), 32'd0);
    check("rd_arready_end", 32'(s_axi.ARREADY), 32'd1);
    check("rd_count", 32'(rd_errors), 32'(exp_rd));
  endtask

  task automatic do_write(input logic [1:0] id, input int nbeats, input int bdelay, input bit early);
    int k;
    int cyc;
    bit hs;
    if (early) begin
      s_axi.WVALID = 1'b1;
      s_axi.WLAST  = (nbeats == 1);
      for (int i = 0; i < 4; i++) begin
        check("wr_wready_early", 32'(s_axi.WREADY), 32'd0);
        tick();
      end
    end
    check("wr_awready", 32'(s_axi.AWREADY), 32'd1);
    check("wr_wready_aw", 32'(s_axi.WREADY), 32'd0);
    s_axi.AWVALID = 1'b1;
    s_axi.AWID    = id;
    tick();
    s_axi.AWVALID = 1'b0;
    s_axi.AWID    = '0;
    check("wr_awready_busy", 32'(s_axi.AWREADY), 32'd0);
    k   = 0;
    cyc = 0;
    while (k < nbeats && cyc < 600) begin
      s_axi.WVALID = 1'b1;
      s_axi.WLAST  = (k == nbeats - 1);
      check("wr_wready", 32'(s_axi.WREADY), 32'd1);
      check("wr_bvalid_data", 32'(s_axi.BVALID), 32'd0);
      hs = s_axi.WREADY;
      tick();
      cyc++;
      if (hs) k++;
    end
    s_axi.WVALID = 1'b0;
    s_axi.WLAST  = 1'b0;
    check("wr_beats", 32'(k), 32'(nbeats));
    check("wr_wready_done", 32'(s_axi.WREADY), 32'd0);
    for (int i = 0; i <= bdelay; i++) begin
      s_axi.BREADY = (i == bdelay);
      check("wr_bvalid", 32'(s_axi.BVALID), 32'd1);
      check("wr_bid", 32'(s_axi.BID), 32'(id));
      check("wr_bresp", 32'(s_axi.BRESP), 32'd3);
      tick();
    end
    s_axi.BREADY = 1'b0;
    exp_wr++;
    check("wr_bvalid_end", 32'(s_axi.BVALID), 32'd0);
    check("wr_awready_end", 32'(s_axi.AWREADY), 32'd1);
    check("wr_count", 32'(wr_errors), 32'(exp_wr));
  endtask

  initial begin
    rst = 1'b1;
    s_axi.AWVALID = 1'b0; s_axi.AWID = '0; s_axi.WVALID = 1'b0; s_axi.WLAST = 1'b0;
    s_axi.BREADY  = 1'b0; s_axi.ARVALID = 1'b0; s_axi.ARID = '0; s_axi.ARLEN = '0;
    s_axi.RREADY  = 1'b0;
    s2.AWVALID = 1'b0; s2.AWID = '0; s2.WVALID = 1'b0; s2.WLAST = 1'b0;
    s2.BREADY  = 1'b0; s2.ARVALID = 1'b0; s2.ARID = '0; s2.ARLEN = '0;
    s2.RREADY  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_awready", 32'(s_axi.AWREADY), 32'd1);
    check("rst_arready", 32'(s_axi.ARREADY), 32'd1);
    check("rst_wready", 32'(s_axi.WREADY), 32'd0);
    check("rst_bvalid", 32'(s_axi.BVALID), 32'd0);
    check("rst_rvalid", 32'(s_axi.RVALID), 32'd0);
    check("rst_rlast", 32'(s_axi.RLAST), 32'd0);
    check("rst_ids", 32'({s_axi.BID, s_axi.RID}), 32'd0);
    check("rst_counts", {wr_errors, rd_errors}, 32'd0);

    // Saturating 2-bit counter, RID gated to zero when idle, SLVERR response
    for (int i = 0; i < 5; i++) begin
      s2.ARVALID = 1'b1; s2.ARID = 2'd3; s2.ARLEN = 8'd0; s2.RREADY = 1'b1;
      check("lp_rid_idle", 32'(s2.RID), 32'd0);
      tick();
      s2.ARVALID = 1'b0; s2.ARID = '0;
      check("lp_rvalid", 32'(s2.RVALID), 32'd1);
      check("lp_rid", 32'(s2.RID), 32'd3);
      check("lp_rresp", 32'(s2.RRESP), 32'd2);
      tick();
      check("lp_rid_after", 32'(s2.RID), 32'd0);
      check("lp_rlast_after", 32'(s2.RLAST), 32'd0);
      check("lp_count", 32'(rd_errors2), 32'((i + 1 > 3) ? 3 : i + 1));
    end
    s2.RREADY = 1'b0;
    check("lp_bid_idle", 32'(s2.BID), 32'd0);

    do_read(2'd2, 8'd0, 1'b0);
    do_read(2'd1, 8'd3, 1'b1);
    do_write(2'd3, 5, 3, 1'b0);
    do_write(2'd1, 3, 0, 1'b1);
    fork
      do_read(2'd0, 8'd255, 1'b0);
      do_write(2'd2, 1, 0, 1'b0);
    join

    // Reset while beat 2 of an 8-beat read is on the bus
    s_axi.ARVALID = 1'b1; s_axi.ARID = 2'd1; s_axi.ARLEN = 8'd7; s_axi.RREADY = 1'b1;
    tick();
    s_axi.ARVALID = 1'b0; s_axi.ARID = '0; s_axi.ARLEN = '0;
    tick();
    check("mid_rvalid_before", 32'(s_axi.RVALID), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_axi.RREADY = 1'b0;
    check("mid_rvalid", 32'(s_axi.RVALID), 32'd0);
    check("mid_arready", 32'(s_axi.ARREADY), 32'd1);
    check("mid_rlast", 32'(s_axi.RLAST), 32'd0);
    check("mid_rid", 32'(s_axi.RID), 32'd0);
    check("mid_counts", {wr_errors, rd_errors}, 32'd0);
    exp_rd = 0;
    exp_wr = 0;
    do_read(2'd1, 8'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
